result_deskew: RTL and testbench
================================

RESULT_DESKEW -- requirements
Module: result_deskew

Interface
REQ-001 Parameter BITS_C, default 16, is the signed width of one systolic-array result element.
REQ-002 Parameter DIM, default 8, is the array dimension, i.e. the lane count and the row count.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port en, input, 1 bit: the current beat of the skewed result stream is valid.
REQ-006 Port clr, input, 1 bit: synchronous return to IDLE.
REQ-007 Port Cin, input, DIM x BITS_C signed: skewed column outputs from the array, one element per lane.
REQ-008 Port Crow, input, $clog2(DIM) bits: row address for the read port.
REQ-009 Port Cout, output, DIM x BITS_C signed: registered read data, one full row.
REQ-010 Port busy, output, 1 bit: high in FILL.
REQ-011 Port done, output, 1 bit: high in DONE.

Function
REQ-012 The block SHALL accept the rhombus-shaped stream produced by the array: for row r, lane j is presented on the beat whose index is r+j, beats numbered 0 to 2*DIM-2.
REQ-013 The block SHALL delay lane j by DIM-1-j accepted beats, so lane DIM-1 has no delay and lane 0 has DIM-1 stages.
REQ-014 Delay stages SHALL advance only on cycles with en=1; en=0 stalls all lanes and the beat counter with no data loss.
REQ-015 After delay, aligned row r appears on accepted beat r+DIM-1 and SHALL be written into internal storage row r on that same clock edge.
REQ-016 The state machine SHALL have three states, IDLE, FILL and DONE.
REQ-017 IDLE to FILL on en=1; that cycle's Cin is accepted as beat 0.
REQ-018 In FILL the beat counter SHALL increment on each accepted beat.
REQ-019 FILL to DONE on the edge that accepts beat 2*DIM-2, which is also the edge that writes row DIM-1.
REQ-020 In DONE, en SHALL be ignored and storage SHALL hold its contents.
REQ-021 DONE to IDLE on clr=1.
REQ-022 clr=1 in FILL SHALL abort to IDLE, zero the beat counter and zero all delay stages; rows already written SHALL remain unchanged.
REQ-023 clr SHALL take priority over en in the same cycle.
REQ-024 Storage SHALL NOT be cleared by clr.
REQ-025 Cout SHALL be registered: it equals storage row Crow one cycle after Crow is sampled, in every state.
REQ-026 A read of a row written on the same edge SHALL return the pre-write (old) data.
REQ-027 No arithmetic SHALL be applied; values pass through bit-exact, with sign preserved.
REQ-028 busy and done SHALL be decoded directly from state registers, with no combinational path from inputs.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, a zero beat counter, all delay stages zero, all storage rows zero, Cout zero, busy=0 and done=0.
REQ-030 Reset asserted mid-FILL SHALL discard the partial frame; after release the block SHALL wait in IDLE for a fresh beat 0.

Structure
REQ-031 BITS_C and DIM defaults, plus the state enumeration type (IDLE/FILL/DONE), SHALL reside in the shared tpu_pkg package.
REQ-032 One sub-module, deskew_lane, SHALL implement a parameterised-depth delay line with enable, supporting depth 0; it SHALL be instantiated DIM times by generate.
REQ-033 Storage SHALL be a DIM x DIM register array with no memory macro.

Verification
REQ-034 DIM=8, Cin lane j on beat b = 100*(b-j)+j when 0<=b-j<=7, else 0x7FFF, with en=1 for 15 cycles -> done after beat 14; reading Crow=r gives Cout[j]=100*r+j; garbage values never stored.
REQ-035 Same stream with en=0 inserted for 3 cycles after beat 5 -> identical stored contents; busy stays high through the stall; done rises 3 cycles later than in REQ-034.
REQ-036 clr pulsed after beat 9 -> IDLE; rows 0-2 hold new data, rows 3-7 hold prior data; a new frame with values +1 completes correctly.
REQ-037 Crow=2 held while the frame streams -> Cout changes from old to new row-2 data exactly one cycle after the beat-9 edge.
REQ-038 rst_n pulled low asynchronously mid-cycle after beat 6 -> immediate zero outputs and IDLE; all rows read 0 afterwards.
REQ-039 A negative full-scale value (-32768) on lane 0 row 7 -> read back bit-exact as -32768.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared across the TPU result path.
//   BITS_C_DEF / DIM_DEF : default element width and array dimension
//   deskew_state_e       : result_deskew frame state
package tpu_pkg;

    localparam int unsigned BITS_C_DEF = 16;
    localparam int unsigned DIM_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } deskew_state_e;

endpackage

// File: rtl/result_deskew_if.sv
// result_deskew_if: stream-in / row-read bus of result_deskew.
//   en, clr : beat valid, synchronous return to IDLE
//   Cin     : skewed column outputs, one signed BITS_C element per lane
//   Crow    : row address of the read port
//   Cout    : registered read data, one full row
//   busy    : frame being filled; done : frame complete
// master drives the stream and read address; slave is the deskew block.
interface result_deskew_if
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_C = BITS_C_DEF,
    parameter int unsigned DIM    = DIM_DEF
);
    localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic                         en;
    logic                         clr;
    logic [DIM-1:0][BITS_C-1:0]   Cin;
    logic [ROW_W-1:0]             Crow;
    logic [DIM-1:0][BITS_C-1:0]   Cout;
    logic                         busy;
    logic                         done;

    modport master (
        output en, clr, Cin, Crow,
        input  Cout, busy, done
    );

    modport slave (
        input  en, clr, Cin, Crow,
        output Cout, busy, done
    );

endinterface

// File: rtl/result_deskew_lane.sv
// deskew_lane: delay line of DEPTH stages that advances only when en=1.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift one stage
//   clr        : synchronously zero all stages (priority over en)
//   din / dout : element in / element DEPTH accepted beats old
// DEPTH=0 is a plain wire.
module deskew_lane
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_C = BITS_C_DEF,
    parameter int unsigned DEPTH  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [BITS_C-1:0] din,
    output logic [BITS_C-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
            // Control inputs have no function without stages.
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst_n, en, clr};
        end else begin : g_pipe
            logic [BITS_C-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (clr) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (en) begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/result_deskew.sv
// result_deskew: realigns the rhombus-shaped result stream of a DIM x DIM
// systolic array into DIM rows held in a register array.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : result_deskew_if.slave (en, clr, Cin in; Crow read address;
//                Cout registered row; busy = FILL, done = DONE)
// Row r lane j arrives on beat r+j. Lane j is delayed DIM-1-j accepted beats,
// so the whole of row r is aligned on beat r+DIM-1 and written that edge.
module result_deskew
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_C = BITS_C_DEF,
    parameter int unsigned DIM    = DIM_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    result_deskew_if.slave  bus
);

    localparam int unsigned ROW_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned BEAT_W = $clog2(2 * DIM);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * DIM - 2);
    localparam logic [BEAT_W-1:0] FIRST_WR  = BEAT_W'(DIM - 1);

    deskew_state_e               state, state_nx;
    logic [BEAT_W-1:0]           beat, beat_nx;
    logic                        accept;
    logic                        wr;
    logic [ROW_W-1:0]            wr_row;
    logic [DIM-1:0][BITS_C-1:0]  aligned;
    logic [DIM-1:0][BITS_C-1:0]  mem [DIM];

    // Next state and beat counter; clr wins over en in every state.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        accept   = 1'b0;
        if (bus.clr) begin
            state_nx = IDLE;
            beat_nx  = '0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (bus.en) begin
                        accept = 1'b1;
                        if (beat == LAST_BEAT) begin
                            state_nx = DONE;
                            beat_nx  = '0;
                        end else begin
                            state_nx = FILL;
                            beat_nx  = beat + 1'b1;
                        end
                    end
                end
                DONE:    ;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
        end
    end

    generate
        for (genvar j = 0; j < int'(DIM); j++) begin : g_lane
            deskew_lane #(
                .BITS_C (BITS_C),
                .DEPTH  (DIM - 1 - j)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (accept),
                .clr   (bus.clr),
                .din   (bus.Cin[j]),
                .dout  (aligned[j])
            );
        end
    endgenerate

    // Lane outputs are sampled before the shift, so on beat b they carry row b-(DIM-1).
    assign wr     = accept && (beat >= FIRST_WR);
    assign wr_row = ROW_W'(beat - FIRST_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DIM; r++) mem[r] <= '0;
        end else if (wr) begin
            mem[wr_row] <= aligned;
        end
    end

    // Registered read; a same-edge write is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Cout <= '0;
        end else begin
            bus.Cout <= mem[bus.Crow];
        end
    end

    assign bus.busy = (state == FILL);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_result_deskew.sv
// tb_result_deskew: directed stimulus for result_deskew (DIM=8, BITS_C=16).
// A frame-level model (row r lane j = beat r+j) tracks storage, Cout, busy
// and done; a negedge process compares every cycle, and literal checks pin
// the expected row contents, done timing and reset behaviour.
module tb_result_deskew;

    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int NBEAT  = 2 * DIM - 1;

    typedef logic [DIM-1:0][BITS_C-1:0] row_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    result_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

    result_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [BITS_C-1:0] mbeats [NBEAT][DIM];
    logic [BITS_C-1:0] mmem   [DIM][DIM];
    row_t              exp_cout;
    int                mst;    // 0 idle, 1 fill, 2 done
    int                mbeat;
    bit                chk_en = 1'b0;

    task automatic model_reset();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) mmem[r][j] = '0;
        exp_cout = '0;
        mst      = 0;
        mbeat    = 0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input row_t cin, input logic [2:0] crow);
        int r;
        for (int j = 0; j < DIM; j++) exp_cout[j] = mmem[crow][j];
        if (clr) begin
            mst   = 0;
            mbeat = 0;
        end else if (en && mst != 2) begin
            for (int j = 0; j < DIM; j++) mbeats[mbeat][j] = cin[j];
            if (mbeat >= DIM - 1) begin
                r = mbeat - (DIM - 1);
                for (int j = 0; j < DIM; j++) mmem[r][j] = mbeats[r + j][j];
            end
            if (mbeat == NBEAT - 1) begin
                mst   = 2;
                mbeat = 0;
            end else begin
                mst   = 1;
                mbeat = mbeat + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("cout", bus.Cout, exp_cout);
            check("busy", bus.busy, (mst == 1));
            check("done", bus.done, (mst == 2));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic row_t beat_vec(input int b, input int off, input bit neg);
        row_t v;
        int   d;
        for (int j = 0; j < DIM; j++) begin
            d = b - j;
            if (d >= 0 && d <= DIM - 1) v[j] = BITS_C'(100 * d + j + off);
            else                        v[j] = 16'h7FFF;
            if (neg && j == 0 && b == DIM - 1) v[j] = 16'h8000;
        end
        return v;
    endfunction

    function automatic row_t row_vec(input int r, input int off);
        row_t v;
        for (int j = 0; j < DIM; j++) v[j] = BITS_C'(100 * r + j + off);
        return v;
    endfunction

    task automatic cyc(input logic en, input logic clr, input row_t cin, input logic [2:0] crow);
        bus.en   = en;
        bus.clr  = clr;
        bus.Cin  = cin;
        bus.Crow = crow;
        @(posedge clk);
        if (rst_n) model_edge(en, clr, cin, crow);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '1, 3'd0);
    endtask

    task automatic clear();
        cyc(1'b0, 1'b1, '1, 3'd0);
    endtask

    // Streams one frame; returns the cycle (1-based from beat 0) where done was first seen.
    task automatic run_frame(input int off, input bit neg, input logic [2:0] crow,
                             input int stall_after, input int stall_len, input bit watch2,
                             output int done_cyc);
        int cycles = 0;
        done_cyc = -1;
        for (int b = 0; b < NBEAT; b++) begin
            cyc(1'b1, 1'b0, beat_vec(b, off, neg), crow);
            cycles++;
            if (bus.done && done_cyc < 0) done_cyc = cycles;
            if (watch2 && b == 9)  check("row2_old_at_beat9", bus.Cout[0], 16'd201);
            if (watch2 && b == 10) check("row2_new_after",    bus.Cout[0], 16'd200);
            if (b == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    cyc(1'b0, 1'b0, '1, crow);
                    cycles++;
                    check("busy_in_stall", bus.busy, 1'b1);
                    if (bus.done && done_cyc < 0) done_cyc = cycles;
                end
            end
        end
    endtask

    task automatic read_row(input int r, input int off, input string name);
        cyc(1'b0, 1'b0, '1, 3'(r));
        check(name, bus.Cout, row_vec(r, off));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dc;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.clr  = 1'b0;
        bus.Cin  = '0;
        bus.Crow = '0;
        model_reset();
        #12;
        check("reset_cout", bus.Cout, '0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Plain frame: done after the 15th beat.
        run_frame(0, 1'b0, 3'd0, -1, 0, 1'b0, dc);
        check("frameA_done_cycle", dc, 15);
        // en ignored in DONE
        repeat (3) cyc(1'b1, 1'b0, {DIM{16'h1234}}, 3'd0);
        check("done_holds", bus.done, 1'b1);
        for (int r = 0; r < DIM; r++) read_row(r, 0, "frameA_row");
        clear();
        check("clr_from_done", bus.done, 1'b0);

        // Abort after beat 9: rows 0-2 new (+1), rows 3-7 keep frame A.
        for (int b = 0; b <= 9; b++) cyc(1'b1, 1'b0, beat_vec(b, 1, 1'b0), 3'd0);
        clear();
        check("abort_busy", bus.busy, 1'b0);
        for (int r = 0; r < DIM; r++) read_row(r, (r <= 2) ? 1 : 0, "abort_row");

        // Fresh frame with +1 values.
        run_frame(1, 1'b0, 3'd0, -1, 0, 1'b0, dc);
        check("frameB_done_cycle", dc, 15);
        for (int r = 0; r < DIM; r++) read_row(r, 1, "frameB_row");
        clear();

        // Stalled frame, Crow=2 held: old row 2 (+1) until one cycle after beat 9.
        run_frame(0, 1'b0, 3'd2, 5, 3, 1'b1, dc);
        check("stall_done_cycle", dc, 18);
        for (int r = 0; r < DIM; r++) read_row(r, 0, "stall_row");
        clear();

        // Negative full scale on lane 0 row 7.
        run_frame(2, 1'b1, 3'd0, -1, 0, 1'b0, dc);
        cyc(1'b0, 1'b0, '1, 3'd7);
        check("neg_fullscale", bus.Cout[0], 16'h8000);
        check("row7_lane1", bus.Cout[1], 16'd703);
        clear();

        // Asynchronous reset mid-frame after beat 6.
        for (int b = 0; b <= 6; b++) cyc(1'b1, 1'b0, beat_vec(b, 5, 1'b0), 3'd0);
        check("busy_before_rst", bus.busy, 1'b1);
        bus.en = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, bus.Cin, bus.Crow);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_cout", bus.Cout, '0);
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("idle_after_rst", bus.busy, 1'b0);
        for (int r = 0; r < DIM; r++) begin
            cyc(1'b0, 1'b0, '1, 3'(r));
            check("rst_row_zero", bus.Cout, '0);
        end
        run_frame(3, 1'b0, 3'd0, -1, 0, 1'b0, dc);
        check("frameC_done_cycle", dc, 15);
        for (int r = 0; r < DIM; r++) read_row(r, 3, "frameC_row");
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
